// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, holds the unit busy for a fixed latency
// per operation and raises the Decode stall for MD-class instructions.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [1:0]  we,
    input  logic        md_in_d,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic              done_q, done_d;

    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic               sgn;
    logic [31:0]        a_mag, b_mag, b_safe, uq, ur, quo, rem;
    logic [31:0]        res_hi, res_lo;

    assign sprod = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
    assign uprod = {32'b0, d1} * {32'b0, d2};

    // Signed division runs on magnitudes so the 0x80000000 / -1 case needs no special path.
    assign sgn    = (op == 3'd2);
    assign a_mag  = (sgn && d1[31]) ? -d1 : d1;
    assign b_mag  = (sgn && d2[31]) ? -d2 : d2;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq     = a_mag / b_safe;
    assign ur     = a_mag % b_safe;
    assign quo    = (sgn && (d1[31] ^ d2[31])) ? -uq : uq;
    assign rem    = (sgn && d1[31]) ? -ur : ur;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op)
            3'd0: begin res_hi = sprod[63:32]; res_lo = sprod[31:0]; end
            3'd1: begin res_hi = uprod[63:32]; res_lo = uprod[31:0]; end
            3'd2, 3'd3: begin
                if (d2 != 32'd0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        cnt_d     = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d   = RUN;
                    end
                end else if (we == 2'd1) begin
                    hi_d = d1;
                end else if (we == 2'd2) begin
                    lo_d = d1;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = md_in_d & (start | busy);
endmodule

// File: tb/tb_md_sequencer.sv
// Randomized and directed bench for md_sequencer against an arithmetic model of HI/LO.
module tb_md_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] d1, d2;
    logic [1:0]  we;
    logic        md_in_d;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
        .we(we), .md_in_d(md_in_d), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .stall(stall)
    );

    always #5 clk = ~clk;

    // Starting while busy is a protocol error the bench should never commit.
    always @(negedge clk) begin
        if (reset && start && busy) begin
            miscompares++;
            $display("FAIL protocol: start asserted while busy (busy=%0b start=%0b)", busy, start);
        end
    end

    function automatic int lat(input logic [2:0] o);
        return (o < 3'd2) ? MC : DC;
    endfunction

    // Reference: HI/LO after an MD op from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r, p;
        logic [63:0] ua, ub, up;
        sa = 64'(signed'(a)); sb = 64'(signed'(b));
        ua = {32'b0, a};      ub = {32'b0, b};
        case (o)
            3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd1: begin up = ua * ub; hi_m = up[63:32]; lo_m = up[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; hi_m = r[31:0]; lo_m = q[31:0]; end
            3'd3: if (b != 0) begin up = ua / ub; hi_m = up[31:0]; up = ua % ub; lo_m = hi_m; hi_m = up[31:0]; lo_m = 32'((ua / ub)); end
            default: ;
        endcase
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drives one op and measures busy length, done pulses and stall cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic md, output int nbusy, output int ndone,
                          output int nstall, output logic dn, output logic [31:0] h,
                          output logic [31:0] l);
        nbusy = 0; ndone = 0; nstall = 0;
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b; md_in_d = md; we = 2'd0;
        #1 if (stall) nstall++;
        @(negedge clk);
        start = 1'b0;
        #1;
        while (busy && nbusy < 40) begin
            nbusy++;
            if (stall) nstall++;
            if (done) ndone++;
            @(negedge clk); #1;
        end
        h = hi; l = lo; dn = done;
        if (done) ndone++;
        if (stall) nstall++;
        @(negedge clk); #1;
        if (done) ndone++;
        md_in_d = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 3'd0; d1 = 0; d2 = 0; we = 2'd0; md_in_d = 1'b1;
        idle_cycles(3);
        vectors++;
        if ({busy, done, stall} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%0b done=%0b stall=%0b hi=%h lo=%h, required all 0",
                     busy, done, stall, hi, lo);
        end
        md_in_d = 1'b0;
        reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic check_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic md);
        int nb, nd, ns; logic dn; logic [31:0] h, l;
        model(o, a, b);
        run_op(o, a, b, md, nb, nd, ns, dn, h, l);
        vectors++;
        if (nb != lat(o) || nd != 1 || dn !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timing: busy=%0d done_pulses=%0d done_at_commit=%0b, required %0d/1/1",
                     nm, nb, nd, dn, lat(o));
        end
        vectors++;
        if (h !== hi_m || l !== lo_m) begin
            miscompares++;
            $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", nm, h, l, hi_m, lo_m);
        end
        vectors++;
        if (ns != (md ? lat(o) + 1 : 0)) begin
            miscompares++;
            $display("FAIL %s stall: %0d cycles, required %0d", nm, ns, md ? lat(o) + 1 : 0);
        end
    endtask

    task automatic test_mult();
        check_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        vectors++;
        if (hi_m !== 32'hFFFFFFFF || lo_m !== 32'hFFFFFFF1) begin
            miscompares++;
            $display("FAIL mult_model: hi=%h lo=%h, required FFFFFFFF FFFFFFF1", hi_m, lo_m);
        end
    endtask

    task automatic test_multu_div();
        check_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        vectors++;
        if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
            miscompares++;
            $display("FAIL multu_const: hi=%h lo=%h, required 00000001 FFFFFFFE", hi, lo);
        end
        check_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            miscompares++;
            $display("FAIL div_const: hi=%h lo=%h, required FFFFFFFF FFFFFFFD", hi, lo);
        end
    endtask

    task automatic test_divzero_overflow();
        @(negedge clk); we = 2'd1; d1 = 32'h11;
        @(negedge clk); we = 2'd2; d1 = 32'h22;
        @(negedge clk); we = 2'd0; #1;
        hi_m = 32'h11; lo_m = 32'h22;
        vectors++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            miscompares++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, required 00000011 00000022", hi, lo);
        end
        check_op("divu_zero", 3'd3, 32'h1234, 32'd0, 1'b0);
        check_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            miscompares++;
            $display("FAIL div_ovf_const: hi=%h lo=%h, required 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_stall();
        check_op("stall_md1", 3'd0, 32'd7, 32'd9, 1'b1);
        check_op("stall_md0", 3'd3, 32'd100, 32'd7, 1'b0);
        check_op("stall_div", 3'd2, 32'hFFFFFF00, 32'd3, 1'b1);
    endtask

    task automatic test_ignored_writes();
        int guard;
        model(3'd0, 32'd3, 32'd4);
        @(negedge clk); start = 1'b1; op = 3'd0; d1 = 32'd3; d2 = 32'd4;
        @(negedge clk); start = 1'b0; we = 2'd1; d1 = 32'hABCD;
        idle_cycles(2);
        we = 2'd0;
        guard = 0;
        while (busy && guard < 40) begin guard++; @(negedge clk); end
        vectors++;
        if (hi !== hi_m || lo !== lo_m || guard >= 40) begin
            miscompares++;
            $display("FAIL mthi_busy: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, hi_m, lo_m);
        end
        model(3'd1, 32'd6, 32'd7);
        @(negedge clk); start = 1'b1; op = 3'd1; d1 = 32'd6; d2 = 32'd7; we = 2'd2;
        @(negedge clk); start = 1'b0; we = 2'd0;
        guard = 0;
        while (busy && guard < 40) begin guard++; @(negedge clk); end
        vectors++;
        if (hi !== hi_m || lo !== lo_m || guard != MC) begin
            miscompares++;
            $display("FAIL mtlo_start: hi=%h lo=%h busy=%0d, required hi=%h lo=%h busy=%0d",
                     hi, lo, guard, hi_m, lo_m, MC);
        end
        @(negedge clk); start = 1'b1; op = 3'd5; d1 = 32'h5555; we = 2'd2;
        @(negedge clk); start = 1'b0; we = 2'd0; #1;
        vectors++;
        if (busy !== 1'b0 || lo !== lo_m || hi !== hi_m) begin
            miscompares++;
            $display("FAIL invalid_op: busy=%0b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                     busy, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        @(negedge clk); start = 1'b1; op = 3'd2; d1 = 32'd1000; d2 = 32'd7;
        @(negedge clk); start = 1'b0;
        idle_cycles(2);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%0b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
        end
        hi_m = 32'd0; lo_m = 32'd0;
        nd = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) nd++; end
        reset = 1'b1;
        for (int i = 0; i < DC + 2; i++) begin @(negedge clk); #1 if (done || busy) nd++; end
        vectors++;
        if (nd != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abandon: done/busy seen %0d times hi=%h lo=%h, required 0/0/0",
                     nd, hi, lo);
        end
        check_op("post_reset_mult", 3'd0, 32'h00010000, 32'h00010000, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0] o; logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 28);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); we = 2'($urandom_range(1, 2)); d1 = $urandom();
                if (we == 2'd1) hi_m = d1; else lo_m = d1;
                @(negedge clk); we = 2'd0;
            end
            check_op("random", o, a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_div();
        test_divzero_overflow();
        test_stall();
        test_ignored_writes();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
